// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   MULT_WIDTH  : operand width (fixed at 4 to match the adder stage)
//   PROD_WIDTH  : product width
//   STEP_COUNT  : number of shift-and-add iterations per operation
//   CNT_WIDTH   : width of the step counter
//   state_e     : controller states
package shift_add_mult_pkg;

  localparam int unsigned MULT_WIDTH = 4;
  localparam int unsigned PROD_WIDTH = 2 * MULT_WIDTH;
  localparam int unsigned STEP_COUNT = MULT_WIDTH;
  localparam int unsigned CNT_WIDTH  = $clog2(STEP_COUNT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/rcadder.sv
// Ripple-carry adder, the team's basic add stage.
// Ports:
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_sum    : sum bits
//   o_cout   : carry out of the top bit
module rcadder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // A scalar carry walks the chain so no vector feeds back on itself.
  logic w_carry;

  always_comb begin
    o_sum   = '0;
    w_carry = i_cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one shift-and-add step per cycle using rcadder.
// A start pulse in idle captures the operands; after four steps the product is
// registered and done pulses for one cycle.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   i_start   : request, only sampled while idle
//   i_a       : multiplicand
//   i_b       : multiplier
//   o_busy    : high while running and during the done cycle
//   o_done    : one-cycle completion pulse
//   o_product : registered product, held until the next completion
// Build option:
//   MULT_ZERO_SKIP_EN : a zero operand skips straight to done with product 0.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  // Only 4 is supported; it must match the adder stage.
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic [WIDTH-1:0]     w_q_nxt;
  logic                 w_last;
  logic                 w_zero_op;

  // Add stage: acc + m, carry in tied low.
  rcadder #(
    .WIDTH (WIDTH)
  ) u_add (
    .i_a    (r_acc),
    .i_b    (r_m),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // One step: add when the multiplier LSB is set, then shift {carry, acc, q} right.
  // The carry lands in acc's MSB, so the result never overflows.
  always_comb begin
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    if (r_q[0]) begin
      {w_acc_nxt, w_q_nxt} = {w_cout, w_sum, r_q[WIDTH-1:1]};
    end else begin
      {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[WIDTH-1:1]};
    end
  end

  assign w_last    = (r_cnt == CNT_WIDTH'(STEP_COUNT - 1));
  assign w_zero_op = (i_a == '0) || (i_b == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
`ifdef MULT_ZERO_SKIP_EN
          w_state_nxt = w_zero_op ? StDone : StRun;
`else
          w_state_nxt = StRun;
`endif
        end
      end
      StRun: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_m   <= i_a;
            r_q   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef MULT_ZERO_SKIP_EN
            if (w_zero_op) begin
              r_product <= '0;
            end
`endif
          end
        end
        StRun: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (w_last) begin
            r_product <= {w_acc_nxt, w_q_nxt};
          end
        end
        default: ;
      endcase
    end
  end

`ifndef MULT_ZERO_SKIP_EN
  // Only consumed by the zero-skip path.
  logic w_unused_zero;
  assign w_unused_zero = w_zero_op;
`endif

  assign o_product = r_product;

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_a = '0;
  logic [3:0] i_b = '0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_product;

  typedef struct {
    logic [7:0] prod;
    int         edge_no;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_lat;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;

  shift_add_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled mid-cycle, inputs only move just after posedge.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      n_done++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL done_unexpected product=%h with no pending operation", o_product);
      end else begin
        mon_e = sb.pop_front();
        if (o_product !== mon_e.prod) begin
          n_errors++;
          $display("FAIL sb_product got=%h exp=%h", o_product, mon_e.prod);
        end
        n_checks++;
        if (cyc - mon_e.edge_no + 1 != mon_e.lat) begin
          n_errors++;
          $display("FAIL sb_latency got=%0d exp=%0d", cyc - mon_e.edge_no + 1, mon_e.lat);
        end
      end
    end
    if (rst_n && i_start && !o_busy) begin
`ifdef MULT_ZERO_SKIP_EN
      mon_lat = (i_a == 4'd0 || i_b == 4'd0) ? 1 : 5;
`else
      mon_lat = 5;
`endif
      sb.push_back('{prod: 8'({4'b0, i_a} * {4'b0, i_b}), edge_no: cyc + 1, lat: mon_lat});
    end
  end

  // Caller is in the phase just after a posedge and the DUT is idle.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    bit ok = 1'b0;
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL accept_timeout busy=%b exp=1", o_busy);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!o_busy && sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL idle_timeout busy=%b pending=%0d exp busy=0 pending=0", o_busy, sb.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_product} !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got=%b/%b/%h exp=0/0/00", o_busy, o_done, o_product);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    i_a = 4'd13;
    i_b = 4'd11;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_c1 busy/done=%b%b exp=10", o_busy, o_done);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (o_busy !== 1'b1 || o_done !== (k == 4)) begin
        n_errors++;
        $display("FAIL basic_c%0d busy/done=%b%b exp=1%b", k + 1, o_busy, o_done, k == 4);
      end
    end
    n_checks++;
    if (o_product !== 8'h8F) begin
      n_errors++;
      $display("FAIL basic_product got=%h exp=8f", o_product);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_product !== 8'h8F) begin
      n_errors++;
      $display("FAIL basic_after got=%b%b/%h exp=00/8f", o_busy, o_done, o_product);
    end
  endtask

  task automatic test_carry_back_to_back();
    int d0 = n_done;
    wait_idle();
    issue(4'd15, 4'd15);
    i_a = 4'd1;
    i_b = 4'd1;
    i_start = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    wait_idle();
    n_checks++;
    if (o_product !== 8'h01 || n_done - d0 != 2) begin
      n_errors++;
      $display("FAIL back_to_back got=%h dones=%0d exp=01 dones=2", o_product, n_done - d0);
    end
  endtask

  task automatic test_start_ignored();
    int d0;
    wait_idle();
    d0 = n_done;
    issue(4'd7, 4'd3);
    i_a = 4'd2;
    i_b = 4'd2;
    for (int k = 0; k < 5; k++) begin
      i_start = (k % 2 == 0);
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    wait_idle();
    n_checks++;
    if (o_product !== 8'h15 || n_done - d0 != 1) begin
      n_errors++;
      $display("FAIL start_ignored got=%h dones=%0d exp=15 dones=1", o_product, n_done - d0);
    end
  endtask

  task automatic test_reset_midrun();
    int d0;
    wait_idle();
    issue(4'd9, 4'd9);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_done, o_product} !== 10'd0) begin
      n_errors++;
      $display("FAIL midrun_reset got=%b/%b/%h exp=0/0/00", o_busy, o_done, o_product);
    end
    sb.delete();
    d0 = n_done;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (n_done != d0 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_discard dones=%0d busy=%b exp dones=0 busy=0", n_done - d0, o_busy);
    end
    issue(4'd3, 4'd5);
    wait_idle();
    n_checks++;
    if (o_product !== 8'h0F) begin
      n_errors++;
      $display("FAIL after_reset_product got=%h exp=0f", o_product);
    end
  endtask

  task automatic test_zero();
    int d0;
    wait_idle();
    d0 = n_done;
    issue(4'd0, 4'd9);
    wait_idle();
    n_checks++;
    if (o_product !== 8'h00 || n_done - d0 != 1) begin
      n_errors++;
      $display("FAIL zero_operand got=%h dones=%0d exp=00 dones=1", o_product, n_done - d0);
    end
  endtask

  task automatic test_sweep();
    int d0;
    logic [7:0] exp_p;
    wait_idle();
    d0 = n_done;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4'(a), 4'(b));
        wait_idle();
        exp_p = 8'(a * b);
        n_checks++;
        if (o_product !== exp_p) begin
          n_errors++;
          $display("FAIL sweep_%0dx%0d got=%h exp=%h", a, b, o_product, exp_p);
        end
      end
    end
    n_checks++;
    if (n_done - d0 != 256) begin
      n_errors++;
      $display("FAIL sweep_done_count got=%0d exp=256", n_done - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_back_to_back();
    test_start_ignored();
    test_reset_midrun();
    test_zero();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
